ahbl_cache_bridge: RTL

- AHB-Lite subordinate that turns Hazard3 bus transfers into the strobe/busy request protocol served by the cached SDRAM memory controller: `m_rd_en`/`m_wr_en` strobes, `m_addr`/`m_wdata`/`m_mask`, and `m_busy`/`m_rdata` back.
- It is the initiator for that controller. It sits between the CPU bus fabric and the memory controller.
- It also generates byte masks, rejects misaligned transfers, and bounds wait time with a timeout.

---
 rtl/ahbl_cache_bridge.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ahbl_cache_bridge.sv
// ahbl_cache_bridge
//   AHB-Lite subordinate that converts CPU bus transfers into the strobe/busy
//   request protocol of the cached SDRAM controller. It builds the byte mask
//   from hsize/haddr, turns misaligned transfers into a two-cycle ERROR, and
//   limits data-phase waiting with an optional timeout.
//
//   Ports
//     clk, rst           system clock, async active-high reset
//     hsel, htrans,      AHB-Lite address phase
//     hwrite, hsize,
//     haddr, hready
//     hwdata             AHB write data (data phase)
//     hreadyout, hresp,  AHB response
//     hrdata
//     m_rd_en, m_wr_en   one-cycle request strobes to the controller
//     m_addr, m_wdata,   request address / data / byte enables
//     m_mask
//     m_busy, m_rdata    controller status and read data
//
//   state | meaning
//   IDLE  | no transfer in data phase, zero-wait OKAY
//   ISSUE | data phase, waiting for m_busy=0 to fire the strobe
//   WAIT  | strobe sent, waiting for m_busy=0 (completion) or timeout
//   ERR1  | first ERROR cycle, hreadyout low
//   ERR2  | second ERROR cycle, hreadyout high, next address accepted
module ahbl_cache_bridge #(
  parameter int TIMEOUT = 4096,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic              m_rd_en,
  output logic              m_wr_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_mask,
  input  logic              m_busy,
  input  logic [31:0]       m_rdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       capture;
  logic       accept;
  logic       misaligned;
  logic [3:0] mask_new;
  logic       unused_htrans0;

  assign unused_htrans0 = htrans[0];
  assign capture = hready && hsel && htrans[1];

  always_comb begin
    mask_new   = 4'b0000;
    misaligned = 1'b0;
    case (hsize)
      3'd0: mask_new = 4'b0001 << haddr[1:0];
      3'd1: begin
        if (haddr[0]) misaligned = 1'b1;
        else          mask_new = haddr[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        if (haddr[1:0] != 2'b00) misaligned = 1'b1;
        else                     mask_new = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    m_rd_en   = 1'b0;
    m_wr_en   = 1'b0;
    m_wdata   = wdata_q;
    accept    = 1'b0;

    case (state_q)
      S_IDLE: accept = 1'b1;

      S_ISSUE: begin
        hreadyout = 1'b0;
        m_wdata   = hwdata;
        wdata_d   = hwdata;
        if (!m_busy) begin
          m_wr_en = write_q;
          m_rd_en = !write_q;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        hreadyout = 1'b0;
        if (!m_busy) begin
          hreadyout = 1'b1;
          accept    = 1'b1;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          // Trip on the busy cycle that brings the count to TIMEOUT.
          if (TO_EN && (cnt_q + CNT_W'(1) == TO_VAL)) state_d = S_ERR1;
        end
      end

      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = S_ERR2;
      end

      S_ERR2: begin
        hresp  = 1'b1;
        accept = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // Cycles with hreadyout high end the previous data phase and may take
    // a new address phase without an idle cycle in between.
    if (accept) begin
      state_d = S_IDLE;
      if (capture) begin
        addr_d  = haddr;
        write_d = hwrite;
        mask_d  = mask_new;
        state_d = misaligned ? S_ERR1 : S_ISSUE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      mask_q  <= 4'b0000;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_addr = addr_q;
  assign m_mask = mask_q;
  assign hrdata = m_rdata;

endmodule
